// File: rtl/capture_write_ctrl.sv
// Capture sequencer: pre-fill, trigger wait, post-fill.
// Drives sample-RAM strobes and reports the trigger address.
module capture_write_ctrl #(
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_EN,
  input  logic              Start_Write,
  input  logic              STOP,
  input  logic              FORCE_TRIG,
  input  logic              TRIG_EV_IN,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  output logic              ENABLE_TRIGG,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              WRITE_DONE
);

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST_FILL,
    DONE
  } state_t;

  state_t state, nxt;

  logic              sw_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] pre_lat;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] post_lat;
  logic [ADDR_W-1:0] pre_inc;

  logic cap;
  logic cap_n;
  logic start;
  logic wr;
  logic trig;

  // next state and per-edge write/start/trigger qualifiers
  always_comb begin
    nxt     = state;
    pre_inc = pre_cnt + 1'b1;
    cap     = (state == PRE_FILL) ||
              (state == WAIT_TRIG) ||
              (state == POST_FILL);
    start   = Start_Write & ~sw_q & ~STOP &
              ((state == IDLE) || (state == DONE));
    wr      = cap & CLK_EN & ~STOP;
    trig    = wr & (state == WAIT_TRIG) &
              (TRIG_EV_IN | FORCE_TRIG);
    if (STOP) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start)
            nxt = (PRE_CNT == '0) ? WAIT_TRIG : PRE_FILL;
        end
        PRE_FILL: begin
          if (wr && (pre_inc == pre_lat))
            nxt = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig)
            nxt = (post_lat == '0) ? DONE : POST_FILL;
        end
        POST_FILL: begin
          if (wr && (post_cnt == ADDR_W'(1)))
            nxt = DONE;
        end
        default: nxt = IDLE;
      endcase
    end
    cap_n = (nxt == PRE_FILL) ||
            (nxt == WAIT_TRIG) ||
            (nxt == POST_FILL);
  end

  // state register and start edge detector
  always_ff @(posedge CLK) begin
    sw_q <= Start_Write;
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // write pointer, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr         <= '0;
      pre_cnt      <= '0;
      pre_lat      <= '0;
      post_cnt     <= '0;
      post_lat     <= '0;
      ENABLE_TRIGG <= 1'b0;
      WR_STB       <= 1'b0;
      SRAM_ADDR    <= '0;
      TRIG_ADDR    <= '0;
      BUSY         <= 1'b0;
      WRITE_DONE   <= 1'b0;
    end else begin
      WR_STB       <= wr;
      ENABLE_TRIGG <= (nxt == WAIT_TRIG);
      // busy stays up through the last strobe cycle
      BUSY         <= ~STOP & (cap | cap_n);
      WRITE_DONE   <= (state == DONE) && (nxt == DONE);
      if (wr) begin
        SRAM_ADDR <= wptr;
        wptr      <= wptr + 1'b1;
      end
      if (start) begin
        pre_lat  <= PRE_CNT;
        post_lat <= POST_CNT;
        wptr     <= '0;
        pre_cnt  <= '0;
      end
      if (wr && (state == PRE_FILL))
        pre_cnt <= pre_inc;
      if (trig) begin
        TRIG_ADDR <= wptr;
        post_cnt  <= post_lat;
      end
      if (wr && (state == POST_FILL))
        post_cnt <= post_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_capture_write_ctrl.sv
// Directed bench for capture_write_ctrl.
// Expected strobe addresses are queued and popped per WR_STB.
module tb_capture_write_ctrl;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CLK_EN;
  logic          Start_Write;
  logic          STOP;
  logic          FORCE_TRIG;
  logic          TRIG_EV_IN;
  logic [AW-1:0] PRE_CNT;
  logic [AW-1:0] POST_CNT;
  logic          ENABLE_TRIGG;
  logic          WR_STB;
  logic [AW-1:0] SRAM_ADDR;
  logic [AW-1:0] TRIG_ADDR;
  logic          BUSY;
  logic          WRITE_DONE;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int cyc = 0;
  int en_cnt = 0;
  int en_addr = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int done_rise_cyc = 0;
  logic prev_en = 1'b0;
  logic prev_done = 1'b0;

  capture_write_ctrl #(.ADDR_W(AW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLK_EN       (CLK_EN),
    .Start_Write  (Start_Write),
    .STOP         (STOP),
    .FORCE_TRIG   (FORCE_TRIG),
    .TRIG_EV_IN   (TRIG_EV_IN),
    .PRE_CNT      (PRE_CNT),
    .POST_CNT     (POST_CNT),
    .ENABLE_TRIGG (ENABLE_TRIGG),
    .WR_STB       (WR_STB),
    .SRAM_ADDR    (SRAM_ADDR),
    .TRIG_ADDR    (TRIG_ADDR),
    .BUSY         (BUSY),
    .WRITE_DONE   (WRITE_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (WRITE_DONE) break;
      tick();
    end
    chk("done_timeout", WRITE_DONE, 1);
  endtask

  // scoreboard: every strobe pops one expected address
  always @(negedge CLK) begin
    cyc++;
    if (ENABLE_TRIGG) begin
      en_cnt++;
      en_addr = int'(SRAM_ADDR);
    end
    if (WR_STB) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      chk("strobe_needs_clk_en", prev_en, 1);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        chk("sram_addr", SRAM_ADDR, exp_q.pop_front());
    end
    if (WRITE_DONE && !prev_done)
      done_rise_cyc = cyc;
    prev_done = WRITE_DONE;
    prev_en   = CLK_EN;
  end

  initial begin
    int en0;
    int wr0;
    RST         = 1'b1;
    CLK_EN      = 1'b0;
    Start_Write = 1'b1;
    STOP        = 1'b0;
    FORCE_TRIG  = 1'b0;
    TRIG_EV_IN  = 1'b0;
    PRE_CNT     = '0;
    POST_CNT    = '0;
    repeat (3) tick();
    chk("rst_en_trigg", ENABLE_TRIGG, 0);
    chk("rst_wr_stb", WR_STB, 0);
    chk("rst_sram_addr", SRAM_ADDR, 0);
    chk("rst_trig_addr", TRIG_ADDR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", WRITE_DONE, 0);

    // start level held through reset release
    RST = 1'b0;
    repeat (3) tick();
    chk("held_start_busy", BUSY, 0);
    chk("held_start_en", ENABLE_TRIGG, 0);
    Start_Write = 1'b0;
    tick();

    // free run
    PRE_CNT    = 4'd4;
    POST_CNT   = 4'd3;
    CLK_EN     = 1'b1;
    TRIG_EV_IN = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    en0 = en_cnt;
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    chk("s1_busy", BUSY, 1);
    wait_done(40);
    tick();
    chk("s1_q_empty", exp_q.size(), 0);
    chk("s1_trig_addr", TRIG_ADDR, 4);
    chk("s1_en_cycles", en_cnt - en0, 1);
    chk("s1_en_after_addr", en_addr, 3);
    chk("s1_done_lag", done_rise_cyc - last_wr_cyc, 1);
    chk("s1_busy_end", BUSY, 0);
    CLK_EN     = 1'b0;
    TRIG_EV_IN = 1'b0;
    tick();

    // sparse sample strobes
    PRE_CNT  = 4'd2;
    POST_CNT = 4'd2;
    for (int i = 0; i < 7; i++) exp_q.push_back(i);
    wr0 = wr_cnt;
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      CLK_EN     = 1'b0;
      TRIG_EV_IN = 1'b1;
      tick();
      tick();
      CLK_EN     = 1'b1;
      TRIG_EV_IN = (k == 5);
      tick();
    end
    CLK_EN     = 1'b0;
    TRIG_EV_IN = 1'b0;
    wait_done(20);
    tick();
    chk("s2_q_empty", exp_q.size(), 0);
    chk("s2_trig_addr", TRIG_ADDR, 4);
    chk("s2_writes", wr_cnt - wr0, 7);

    // pointer wrap
    PRE_CNT  = 4'd2;
    POST_CNT = 4'd1;
    CLK_EN   = 1'b1;
    for (int i = 0; i < 24; i++) exp_q.push_back(i % 16);
    en0 = en_cnt;
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    repeat (22) tick();
    TRIG_EV_IN = 1'b1;
    tick();
    TRIG_EV_IN = 1'b0;
    wait_done(20);
    tick();
    chk("s3_q_empty", exp_q.size(), 0);
    chk("s3_trig_addr", TRIG_ADDR, 6);
    chk("s3_en_cycles", en_cnt - en0, 21);

    // zero pre/post with software trigger
    PRE_CNT    = 4'd0;
    POST_CNT   = 4'd0;
    FORCE_TRIG = 1'b1;
    exp_q.push_back(0);
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    chk("s4_en_trigg", ENABLE_TRIGG, 1);
    chk("s4_busy", BUSY, 1);
    chk("s4_no_start_wr", WR_STB, 0);
    wait_done(10);
    tick();
    FORCE_TRIG = 1'b0;
    chk("s4_q_empty", exp_q.size(), 0);
    chk("s4_trig_addr", TRIG_ADDR, 0);
    chk("s4_done", WRITE_DONE, 1);

    // abort in post fill
    PRE_CNT    = 4'd1;
    POST_CNT   = 4'd5;
    TRIG_EV_IN = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    repeat (4) tick();
    STOP = 1'b1;
    tick();
    chk("s5_stop_wr", WR_STB, 0);
    chk("s5_stop_busy", BUSY, 0);
    chk("s5_stop_done", WRITE_DONE, 0);
    chk("s5_stop_en", ENABLE_TRIGG, 0);
    STOP       = 1'b0;
    TRIG_EV_IN = 1'b0;
    tick();
    chk("s5_q_empty", exp_q.size(), 0);
    chk("s5_trig_addr", TRIG_ADDR, 1);
    chk("s5_idle_busy", BUSY, 0);

    // restart, with a start edge while busy
    PRE_CNT  = 4'd2;
    POST_CNT = 4'd1;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    tick();
    Start_Write = 1'b1;
    tick();
    Start_Write = 1'b0;
    TRIG_EV_IN  = 1'b1;
    tick();
    TRIG_EV_IN = 1'b0;
    wait_done(20);
    tick();
    chk("s6_q_empty", exp_q.size(), 0);
    chk("s6_trig_addr", TRIG_ADDR, 2);
    chk("s6_busy_end", BUSY, 0);

    CLK_EN = 1'b0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
